// File: rtl/rom_arbiter_pkg.sv
// ============================================================================
// Module   : rom_arbiter_pkg
// Brief    : Shared constants, tag type and index-width helper for the ROM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_arbiter_pkg;

    localparam int ROM_LATENCY_MAX = 3;
    localparam int CH_IDX_MAX_W    = 3;

    // Tag carried alongside each ROM read; index wide enough for the largest channel count.
    typedef struct packed {
        logic                    vld;
        logic [CH_IDX_MAX_W-1:0] idx;
    } tag_t;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker: first request at or above the pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_CH = 3,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              vld_o
);

    always_comb begin
        int cand;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = 0;
        // Walk upward from the pointer, wrapping at NUM_CH; the first hit wins.
        for (int k = 0; k < NUM_CH; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!vld_o && req_i[cand]) begin
                vld_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rom_arbiter.sv
// ============================================================================
// Module   : rom_arbiter
// Brief    : Round-robin sharing of one synchronous ROM among note sequencer channels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 16,
    parameter int ROM_LATENCY = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_CH-1:0]            i_req,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] i_addr,
    output logic [NUM_CH-1:0]            o_ack,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [NUM_CH-1:0]            o_valid,
    output logic [ADDR_WIDTH-1:0]        o_rom_addr,
    input  logic [DATA_WIDTH-1:0]        i_rom_data
);

    localparam int IDX_W = clog2(NUM_CH);
    localparam int LAT   = (ROM_LATENCY > ROM_LATENCY_MAX) ? ROM_LATENCY_MAX :
                           ((ROM_LATENCY < 1) ? 1 : ROM_LATENCY);

    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      ptr_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic [ADDR_WIDTH-1:0] rom_addr_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    tag_t                  tag_q [LAT];

    logic [NUM_CH-1:0]     w_gnt;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_arb_vld;
    logic                  w_gnt_vld;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    tag_t                  w_tag_in;
    tag_t                  w_tag_out;
    logic                  w_out_vld;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_arbiter (
        .req_i  (i_req),
        .ptr_i  (ptr_q),
        .gnt_o  (w_gnt),
        .idx_o  (w_idx),
        .vld_o  (w_arb_vld)
    );

    // Reset masks grants so no read can be issued while the block is held in reset.
    assign w_gnt_vld  = w_arb_vld & ~i_rst;
    assign o_ack      = w_gnt_vld ? w_gnt : '0;
    assign w_sel_addr = i_addr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        if (w_gnt_vld) begin
            ptr_d      = (w_idx == IDX_W'(NUM_CH - 1)) ? '0 : w_idx + IDX_W'(1);
            rom_addr_d = w_sel_addr;
        end
    end

    assign o_rom_addr = i_rst ? '0 : rom_addr_d;

    always_comb begin
        w_tag_in     = '0;
        w_tag_in.vld = w_gnt_vld;
        w_tag_in.idx = CH_IDX_MAX_W'(w_idx);
    end

    assign w_tag_out = tag_q[LAT-1];
    assign w_out_vld = w_tag_out.vld & ~i_rst;
    assign o_valid   = w_out_vld ? (NUM_CH'(1) << w_tag_out.idx) : '0;

    always_comb begin
        data_d = data_q;
        if (w_out_vld) begin
            data_d = i_rom_data;
        end
    end

    assign o_data = i_rst ? '0 : data_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q      <= '0;
            rom_addr_q <= '0;
            data_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            data_q     <= data_d;
        end
    end

    // Tag shift register aligned with the ROM's read latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= w_tag_in;
            for (int s = 1; s < LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

endmodule

`default_nettype wire
